// File: rtl/viterbi_acs_sched_pkg.sv
// viterbi_pkg: shared sizing, FSM state type and delay-line payload for the
// Viterbi ACS butterfly scheduler.
package viterbi_pkg;

    localparam int unsigned NUM_STATES   = 64;
    localparam int unsigned BFLY_PER_CYC = 4;
    localparam int unsigned ACS_LAT      = 2;
    localparam int unsigned TB_DEPTH     = 64;

    // Butterfly groups needed to cover every trellis state once per symbol
    localparam int unsigned G       = NUM_STATES / (2 * BFLY_PER_CYC);
    localparam int unsigned GRP_W   = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned COL_W   = GRP_W;
    localparam int unsigned ROW_W   = $clog2(TB_DEPTH);
    localparam int unsigned DRAIN_W = (ACS_LAT > 1) ? $clog2(ACS_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Issue tag that travels alongside the ACS pipeline
    typedef struct packed {
        logic             valid;
        logic [GRP_W-1:0] grp;
    } bfly_tag_t;

endpackage

// File: rtl/viterbi_acs_sched_if.sv
// Scheduler bus: symbol handshake, BMC/ACS issue controls and decision-memory
// write port. Optional traceback trigger signals exist only when
// VITERBI_TB_TRIGGER_EN is defined.
interface viterbi_acs_sched_if;
    import viterbi_pkg::*;

    logic             clear;
    logic             rx_valid;
    logic [1:0]       rx_pair;
    logic             rx_ready;
    logic [1:0]       bmc_pair;
    logic             bfly_valid;
    logic [GRP_W-1:0] bfly_grp;
    logic             bank_sel;
    logic             norm_en;
    logic             metric_init;
    logic             acs_msb_any;
    logic             dec_wr_en;
    logic [ROW_W-1:0] dec_wr_row;
    logic [COL_W-1:0] dec_wr_col;
    logic             sym_done;
`ifdef VITERBI_TB_TRIGGER_EN
    logic             tb_start;
    logic [ROW_W-1:0] tb_row;
`endif

    // Scheduler side
    modport master (
`ifdef VITERBI_TB_TRIGGER_EN
        output tb_start, tb_row,
`endif
        input  clear, rx_valid, rx_pair, acs_msb_any,
        output rx_ready, bmc_pair, bfly_valid, bfly_grp, bank_sel, norm_en,
        output metric_init, dec_wr_en, dec_wr_row, dec_wr_col, sym_done
    );

    // Datapath / source side
    modport slave (
`ifdef VITERBI_TB_TRIGGER_EN
        input  tb_start, tb_row,
`endif
        output clear, rx_valid, rx_pair, acs_msb_any,
        input  rx_ready, bmc_pair, bfly_valid, bfly_grp, bank_sel, norm_en,
        input  metric_init, dec_wr_en, dec_wr_row, dec_wr_col, sym_done
    );

endinterface

// File: rtl/viterbi_acs_sched_delay.sv
// viterbi_delay_line: fixed-depth shift register matching the ACS pipeline
// latency, with a synchronous flush that discards in-flight entries.
module viterbi_delay_line #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout
);

    logic [W-1:0] r_stage [DEPTH];

    // Shift one stage per cycle; flush zeroes every stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_din;
            for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_dout = r_stage[DEPTH-1];

endmodule

// File: rtl/viterbi_acs_sched.sv
// viterbi_acs_sched: sequences butterfly groups over all trellis states per
// received symbol, steers metric banks, produces decision-memory writes and
// carries the normalization flag into the following symbol.
// Optional traceback trigger: define VITERBI_TB_TRIGGER_EN.
module viterbi_acs_sched
    import viterbi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    viterbi_acs_sched_if.master  bus
);

    state_t           r_state,       w_state_nxt;
    logic [GRP_W-1:0] r_grp,         w_grp_nxt;
    logic [DRAIN_W-1:0] r_drain,     w_drain_nxt;
    logic             r_rx_ready,    w_rx_ready_nxt;
    logic [1:0]       r_bmc_pair,    w_bmc_pair_nxt;
    logic             r_bfly_valid,  w_bfly_valid_nxt;
    logic             r_bank_sel,    w_bank_sel_nxt;
    logic             r_norm_en,     w_norm_en_nxt;
    logic             r_norm_acc,    w_norm_acc_nxt;
    logic             r_init_pend,   w_init_pend_nxt;
    logic             r_metric_init, w_metric_init_nxt;
    logic [ROW_W-1:0] r_ptr,         w_ptr_nxt;
    logic             r_sym_done,    w_sym_done_nxt;
`ifdef VITERBI_TB_TRIGGER_EN
    logic             r_tb_start,    w_tb_start_nxt;
    logic [ROW_W-1:0] r_tb_row,      w_tb_row_nxt;
`endif

    bfly_tag_t w_tag_in;
    bfly_tag_t w_tag_out;

    assign w_tag_in = '{valid: r_bfly_valid, grp: r_grp};

    // Issue tags emerge exactly when the ACS decisions for that group are ready
    viterbi_delay_line #(
        .DEPTH (ACS_LAT),
        .W     ($bits(bfly_tag_t))
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.clear),
        .i_din   (w_tag_in),
        .o_dout  (w_tag_out)
    );

    // Next-state and next-output decode; clear overrides everything last
    always_comb begin
        w_state_nxt       = r_state;
        w_grp_nxt         = r_grp;
        w_drain_nxt       = r_drain;
        w_rx_ready_nxt    = 1'b0;
        w_bmc_pair_nxt    = r_bmc_pair;
        w_bfly_valid_nxt  = 1'b0;
        w_bank_sel_nxt    = r_bank_sel;
        w_norm_en_nxt     = r_norm_en;
        w_norm_acc_nxt    = r_norm_acc | (w_tag_out.valid & bus.acs_msb_any);
        w_init_pend_nxt   = r_init_pend;
        w_metric_init_nxt = 1'b0;
        w_ptr_nxt         = r_ptr;
        w_sym_done_nxt    = 1'b0;
`ifdef VITERBI_TB_TRIGGER_EN
        w_tb_start_nxt    = 1'b0;
        w_tb_row_nxt      = r_tb_row;
`endif

        case (r_state)
            IDLE: begin
                if (r_rx_ready && bus.rx_valid) begin
                    w_state_nxt      = RUN;
                    w_grp_nxt        = '0;
                    w_bfly_valid_nxt = 1'b1;
                    w_bmc_pair_nxt   = bus.rx_pair;
                end
            end
            RUN: begin
                if (r_grp == GRP_W'(G - 1)) begin
                    w_state_nxt = DRAIN;
                    w_drain_nxt = '0;
                end else begin
                    w_grp_nxt        = r_grp + GRP_W'(1);
                    w_bfly_valid_nxt = 1'b1;
                end
            end
            DRAIN: begin
                if (r_drain == DRAIN_W'(ACS_LAT - 1)) begin
                    // Last decision write lands this cycle, so the flag is complete
                    w_state_nxt    = DONE;
                    w_sym_done_nxt = 1'b1;
                    w_bank_sel_nxt = ~r_bank_sel;
                    w_ptr_nxt      = r_ptr + ROW_W'(1);
                    w_norm_en_nxt  = w_norm_acc_nxt;
                    w_norm_acc_nxt = 1'b0;
`ifdef VITERBI_TB_TRIGGER_EN
                    if ((w_ptr_nxt == '0) || (w_ptr_nxt == ROW_W'(TB_DEPTH / 2))) begin
                        w_tb_start_nxt = 1'b1;
                        w_tb_row_nxt   = r_ptr;
                    end
`endif
                end else begin
                    w_drain_nxt = r_drain + DRAIN_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_rx_ready_nxt = (w_state_nxt == IDLE);

        // metric_init rises together with rx_ready once reset/clear has released
        if (r_init_pend) begin
            w_metric_init_nxt = 1'b1;
            w_init_pend_nxt   = 1'b0;
        end

        if (bus.clear) begin
            w_state_nxt       = IDLE;
            w_grp_nxt         = '0;
            w_drain_nxt       = '0;
            w_rx_ready_nxt    = 1'b0;
            w_bfly_valid_nxt  = 1'b0;
            w_bank_sel_nxt    = 1'b0;
            w_norm_en_nxt     = 1'b0;
            w_norm_acc_nxt    = 1'b0;
            w_init_pend_nxt   = 1'b1;
            w_metric_init_nxt = 1'b0;
            w_ptr_nxt         = '0;
            w_sym_done_nxt    = 1'b0;
`ifdef VITERBI_TB_TRIGGER_EN
            w_tb_start_nxt    = 1'b0;
            w_tb_row_nxt      = '0;
`endif
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_grp         <= '0;
            r_drain       <= '0;
            r_rx_ready    <= 1'b0;
            r_bmc_pair    <= '0;
            r_bfly_valid  <= 1'b0;
            r_bank_sel    <= 1'b0;
            r_norm_en     <= 1'b0;
            r_norm_acc    <= 1'b0;
            r_init_pend   <= 1'b1;
            r_metric_init <= 1'b0;
            r_ptr         <= '0;
            r_sym_done    <= 1'b0;
`ifdef VITERBI_TB_TRIGGER_EN
            r_tb_start    <= 1'b0;
            r_tb_row      <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_grp         <= w_grp_nxt;
            r_drain       <= w_drain_nxt;
            r_rx_ready    <= w_rx_ready_nxt;
            r_bmc_pair    <= w_bmc_pair_nxt;
            r_bfly_valid  <= w_bfly_valid_nxt;
            r_bank_sel    <= w_bank_sel_nxt;
            r_norm_en     <= w_norm_en_nxt;
            r_norm_acc    <= w_norm_acc_nxt;
            r_init_pend   <= w_init_pend_nxt;
            r_metric_init <= w_metric_init_nxt;
            r_ptr         <= w_ptr_nxt;
            r_sym_done    <= w_sym_done_nxt;
`ifdef VITERBI_TB_TRIGGER_EN
            r_tb_start    <= w_tb_start_nxt;
            r_tb_row      <= w_tb_row_nxt;
`endif
        end
    end

    assign bus.rx_ready    = r_rx_ready;
    assign bus.bmc_pair    = r_bmc_pair;
    assign bus.bfly_valid  = r_bfly_valid;
    assign bus.bfly_grp    = r_grp;
    assign bus.bank_sel    = r_bank_sel;
    assign bus.norm_en     = r_norm_en;
    assign bus.metric_init = r_metric_init;
    assign bus.dec_wr_en   = w_tag_out.valid;
    assign bus.dec_wr_col  = w_tag_out.grp;
    assign bus.dec_wr_row  = r_ptr;
    assign bus.sym_done    = r_sym_done;
`ifdef VITERBI_TB_TRIGGER_EN
    assign bus.tb_start    = r_tb_start;
    assign bus.tb_row      = r_tb_row;
`endif

endmodule

// File: tb/tb_viterbi_acs_sched.sv
// Bench for viterbi_acs_sched: randomized symbols against a per-symbol
// reference model (row pointer, bank parity, normalization flag carried
// to the next symbol) plus directed clear/reset cases.
module tb_viterbi_acs_sched;
    import viterbi_pkg::*;

    localparam int NG    = int'(G);
    localparam int LAT   = int'(ACS_LAT);
    localparam int LAST  = NG + LAT + 1;
    localparam int DEPTH = int'(TB_DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;

    viterbi_acs_sched_if bus();

    viterbi_acs_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cur_sym  = 0;

    // Reference model state
    int m_row, m_bank, m_norm, m_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s sym=%0d observed=%0h expected=%0h", tag, cur_sym, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_row = 0; m_bank = 0; m_norm = 0; m_acc = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rx_ready"},    32'(bus.rx_ready),    32'd0);
        chk({tag, "_bmc_pair"},    32'(bus.bmc_pair),    32'd0);
        chk({tag, "_bfly_valid"},  32'(bus.bfly_valid),  32'd0);
        chk({tag, "_bfly_grp"},    32'(bus.bfly_grp),    32'd0);
        chk({tag, "_bank_sel"},    32'(bus.bank_sel),    32'd0);
        chk({tag, "_norm_en"},     32'(bus.norm_en),     32'd0);
        chk({tag, "_metric_init"}, 32'(bus.metric_init), 32'd0);
        chk({tag, "_dec_wr_en"},   32'(bus.dec_wr_en),   32'd0);
        chk({tag, "_dec_wr_row"},  32'(bus.dec_wr_row),  32'd0);
        chk({tag, "_dec_wr_col"},  32'(bus.dec_wr_col),  32'd0);
        chk({tag, "_sym_done"},    32'(bus.sym_done),    32'd0);
`ifdef VITERBI_TB_TRIGGER_EN
        chk({tag, "_tb_start"},    32'(bus.tb_start),    32'd0);
        chk({tag, "_tb_row"},      32'(bus.tb_row),      32'd0);
`endif
    endtask

    // One cycle with no symbol in flight
    task automatic idle_cycle(input bit exp_init, input bit exp_ready,
                              input bit drv_clear, input bit drv_valid);
        @(posedge clk);
        #1;
        bus.clear       = drv_clear;
        bus.rx_valid    = drv_valid;
        bus.rx_pair     = 2'($urandom);
        bus.acs_msb_any = 1'($urandom);
        @(negedge clk);
        chk("idle_rx_ready",    32'(bus.rx_ready),    32'(exp_ready));
        chk("idle_metric_init", 32'(bus.metric_init), 32'(exp_init));
        chk("idle_bfly_valid",  32'(bus.bfly_valid),  32'd0);
        chk("idle_dec_wr_en",   32'(bus.dec_wr_en),   32'd0);
        chk("idle_sym_done",    32'(bus.sym_done),    32'd0);
        chk("idle_bank_sel",    32'(bus.bank_sel),    32'(m_bank));
        chk("idle_dec_wr_row",  32'(bus.dec_wr_row),  32'(m_row));
        chk("idle_norm_en",     32'(bus.norm_en),     32'(m_norm));
    endtask

    // msb_idx >= 0: flag only that write; -1: sparse random flags; -2: none.
    // stop_c > 0 ends the symbol early after that cycle (optionally with clear).
    task automatic run_symbol(input logic [1:0] pair, input int gap, input int msb_idx,
                              input int stop_c, input bit clear_at_stop);
        int  last_c;
        bit  wr, msb, exp_start;
        int  widx, nrow;
        last_c = (stop_c == 0) ? LAST : stop_c;
        for (int k = 0; k < gap; k++) idle_cycle(1'b0, 1'b1, 1'b0, 1'b0);

        @(posedge clk);
        #1;
        bus.clear       = 1'b0;
        bus.rx_valid    = 1'b1;
        bus.rx_pair     = pair;
        bus.acs_msb_any = 1'($urandom);
        @(negedge clk);
        chk("acc_rx_ready",   32'(bus.rx_ready),   32'd1);
        chk("acc_bfly_valid", 32'(bus.bfly_valid), 32'd0);
        chk("acc_dec_wr_en",  32'(bus.dec_wr_en),  32'd0);
        chk("acc_norm_en",    32'(bus.norm_en),    32'(m_norm));

        for (int c = 1; c <= last_c; c++) begin
            @(posedge clk);
            #1;
            wr   = (c >= LAT + 1) && (c <= LAT + NG);
            widx = c - LAT - 1;
            if (wr) begin
                if (msb_idx >= 0)       msb = (widx == msb_idx);
                else if (msb_idx == -1) msb = ($urandom_range(0, 15) == 0);
                else                    msb = 1'b0;
            end else begin
                msb = 1'($urandom);
            end
            if (wr && msb) m_acc = 1;
            bus.acs_msb_any = msb;
            bus.rx_valid    = (c == LAST) ? 1'b0 : 1'($urandom);
            bus.rx_pair     = 2'($urandom);
            bus.clear       = clear_at_stop && (c == last_c);
            @(negedge clk);
            nrow = (m_row + 1) % DEPTH;
            chk("bfly_valid", 32'(bus.bfly_valid), 32'(c <= NG));
            if (c <= NG) chk("bfly_grp", 32'(bus.bfly_grp), 32'(c - 1));
            chk("dec_wr_en", 32'(bus.dec_wr_en), 32'(wr));
            if (wr) chk("dec_wr_col", 32'(bus.dec_wr_col), 32'(widx));
            chk("dec_wr_row",  32'(bus.dec_wr_row),  32'((c == LAST) ? nrow : m_row));
            chk("sym_done",    32'(bus.sym_done),    32'(c == LAST));
            chk("bank_sel",    32'(bus.bank_sel),    32'((c == LAST) ? (m_bank ^ 1) : m_bank));
            chk("norm_en",     32'(bus.norm_en),     32'((c == LAST) ? m_acc : m_norm));
            chk("rx_ready",    32'(bus.rx_ready),    32'd0);
            chk("bmc_pair",    32'(bus.bmc_pair),    32'(pair));
            chk("metric_init", 32'(bus.metric_init), 32'd0);
`ifdef VITERBI_TB_TRIGGER_EN
            exp_start = (c == LAST) && ((nrow == 0) || (nrow == DEPTH / 2));
            chk("tb_start", 32'(bus.tb_start), 32'(exp_start));
            if (exp_start) chk("tb_row", 32'(bus.tb_row), 32'(m_row));
`endif
        end

        if (stop_c == 0) begin
            m_row  = (m_row + 1) % DEPTH;
            m_bank = m_bank ^ 1;
            m_norm = m_acc;
            m_acc  = 0;
            cur_sym++;
        end
    endtask

    initial begin
        bus.clear       = 1'b0;
        bus.rx_valid    = 1'b0;
        bus.rx_pair     = 2'b00;
        bus.acs_msb_any = 1'b0;
        model_reset();

        // Reset state and first metric_init pulse
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        idle_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle_cycle(1'b0, 1'b1, 1'b0, 1'b0);

        // Directed first symbol, then normalization carry across symbols 3->4->5
        run_symbol(2'b10, 0, -2, 0, 1'b0);
        run_symbol(2'($urandom), 0, -2, 0, 1'b0);
        run_symbol(2'($urandom), 0, -2, 0, 1'b0);
        run_symbol(2'($urandom), 0, 4, 0, 1'b0);
        run_symbol(2'($urandom), 0, -2, 0, 1'b0);
        run_symbol(2'($urandom), 0, -2, 0, 1'b0);

        // Back-to-back random symbols past the row wrap
        for (int i = 0; i < 60; i++) run_symbol(2'($urandom), 0, -1, 0, 1'b0);
        run_symbol(2'($urandom), 0, 0, 0, 1'b0);

        // clear while group 4 is issued
        run_symbol(2'($urandom), 0, -2, 5, 1'b1);
        model_reset();
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle_cycle(1'b0, 1'b1, 1'b0, 1'b0);

        // Held clear with rx_valid asserted: nothing accepted, one metric_init
        idle_cycle(1'b0, 1'b1, 1'b1, 1'b1);
        idle_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        idle_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle_cycle(1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the first DRAIN cycle
        run_symbol(2'($urandom), 0, -1, 0, 1'b0);
        run_symbol(2'($urandom), 0, -2, NG + 1, 1'b0);
        #2 rst = 1'b1;
        #1 check_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        idle_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) run_symbol(2'($urandom), $urandom_range(0, 2), -1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/viterbi_acs_sched.md
Name: viterbi_acs_sched

Overview:
- Sequencer that time-multiplexes a small bank of BMC/ACS butterfly units across all trellis states of the Viterbi decoder.
- Accepts one received symbol pair per handshake and issues butterfly-group indices plus a ping-pong metric-bank select.
- Generates survivor-decision write strobes and addresses for traceback memory.
- Manages path-metric normalization and metric initialization.

Parameters:
- NUM_STATES, 64, trellis states (power of 2, ≥4).
- BFLY_PER_CYC, 4, butterflies processed per cycle; G = NUM_STATES/(2*BFLY_PER_CYC) groups per symbol (default 8).
- ACS_LAT, 2, cycles from bfly_valid to ACS results/decisions valid (≥1).
- TB_DEPTH, 64, rows of decision memory (power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- clear  in  1  synchronous restart of decoding
- rx_valid  in  1  symbol pair available
- rx_pair  in  2  hard-decision received pair
- rx_ready  out  1  scheduler accepts symbol this cycle
- bmc_pair  out  2  registered rx_pair driven to BMC units; held for the whole symbol
- bfly_valid  out  1  butterfly group issued this cycle
- bfly_grp  out  $clog2(G)  butterfly group index
- bank_sel  out  1  metric bank read; write bank = ~bank_sel
- norm_en  out  1  ACS subtracts normalization offset for this symbol
- metric_init  out  1  one-cycle pulse: ACS loads state 0 = 0, all others = max
- acs_msb_any  in  1  from ACS, valid with dec_wr_en: any new metric MSB set
- dec_wr_en  out  1  decision word write strobe
- dec_wr_row  out  $clog2(TB_DEPTH)  symbol pointer
- dec_wr_col  out  $clog2(G)  group index of decision word
- sym_done  out  1  one-cycle pulse per completed symbol

Behaviour:
- Reset values: every output 0; state IDLE; bank_sel = 0; symbol pointer = 0; norm accumulator = 0; norm_en = 0.
- IDLE:
  - rx_ready = 1.
  - On rx_valid, latch rx_pair into bmc_pair and go to RUN; group counter = 0.
- RUN:
  - bfly_valid = 1 with bfly_grp = 0..G-1, one per cycle, for G cycles.
  - After grp G-1, go to DRAIN.
- DRAIN:
  - ACS_LAT cycles, no issue; the decision pipeline empties.
- DONE (1 cycle):
  - sym_done = 1; bank_sel toggles; pointer increments modulo TB_DEPTH (wraps TB_DEPTH-1 → 0).
  - norm_en <= norm accumulator; accumulator cleared. Go to IDLE.
- Decision path:
  - dec_wr_en/dec_wr_col are bfly_valid/bfly_grp delayed exactly ACS_LAT cycles.
  - dec_wr_row = current pointer, constant within a symbol.
  - All G writes complete before DONE.
- Normalization:
  - The accumulator ORs acs_msb_any on every dec_wr_en cycle.
  - acs_msb_any is ignored when dec_wr_en = 0.
  - norm_en is constant across a whole symbol and applies to the symbol after the one that flagged.
- Throughput: one symbol per G + ACS_LAT + 2 cycles, and rx_ready is high only in IDLE. Accept-to-sym_done latency is G + ACS_LAT + 1 cycles.
- clear:
  - Wins over everything in any state. Next cycle: IDLE, pointer 0, bank_sel 0, norm_en 0, accumulator 0.
  - Delayed pipeline stages are flushed, so no dec_wr_en follows.
  - metric_init pulses in the cycle after clear.
  - clear held for multiple cycles keeps the block in IDLE with rx_ready = 0.
  - metric_init pulses once, on the cycle after clear deasserts.
- clear and rx_valid in the same cycle: the symbol is not accepted.
- rst mid-symbol: immediate return to reset values; the partial decision row is abandoned.
- metric_init also pulses in the first cycle after rst deasserts.

Optional Feature:
- Macro: VITERBI_TB_TRIGGER_EN.
- Defined:
  - Adds outputs tb_start (1) and tb_row ($clog2(TB_DEPTH)).
  - In DONE, when the pointer wraps to 0 or reaches TB_DEPTH/2, tb_start pulses with tb_row = the row just written, requesting a traceback.
  - Both outputs are 0 at reset and cleared by clear.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package viterbi_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - localparams for G and the widths of bfly_grp, dec_wr_col and dec_wr_row;
  - the default NUM_STATES, BFLY_PER_CYC, ACS_LAT and TB_DEPTH.
- One sub-module, viterbi_delay_line, is natural: a parameterized ACS_LAT-deep shift register with synchronous flush that carries {valid, grp}.

Test Plan:
- Single symbol (defaults), rx_pair = 2'b10 at cycle 0:
  - bfly_grp 0..7 on cycles 1–8; dec_wr_col 0..7 on cycles 3–10 with row 0.
  - sym_done on cycle 11; bank_sel becomes 1; rx_ready high on cycle 12.
- 65 back-to-back symbols:
  - dec_wr_row goes 0..63 then 0 (wrap).
  - bank_sel alternates each symbol; bmc_pair stable during each RUN.
- acs_msb_any = 1 on only the 5th write of symbol 3: norm_en = 1 for all of symbol 4 and 0 for symbol 5.
- clear asserted during RUN at grp 4:
  - No further bfly_valid or dec_wr_en.
  - Next cycle: IDLE, pointer 0, bank_sel 0; metric_init pulses once.
- rst asserted asynchronously mid-DRAIN:
  - Outputs go 0 immediately.
  - After release, metric_init pulses and the first symbol writes row 0.
- With VITERBI_TB_TRIGGER_EN: 64 symbols give tb_start at the completion of row 31 (tb_row = 31) and row 63 (tb_row = 63).
